int_alu_mc: RTL and testbench
=============================

# int_alu_mc

Parametrised, multi-cycle successor to the 16-bit integer ALU on the shared 256-bit bus. Operand width is configurable. Adds a full double-width multiply result, a sequential divider with remainder, status flags, and optional signed operations. The block is a bus slave selected by `address[15:12]`. Software writes operands and an opcode, then polls status or reads results.

## Interface
Parameters:
- `WIDTH`, 16: operand/result width; legal range 8..128.
- `UNIT_SEL`, `IntAlu`: 4-bit unit select compared against `address[15:12]`.

Ports:
- `Clk`  in  1: single clock. All state updates on the falling edge, consistent with the bus protocol.
- `Reset`  in  1: asynchronous, active-high reset.
- `DataBus`  inout  256: shared bus. Driven only during a selected read, otherwise high-Z.
- `address`  in  16: `[15:12]` unit select, `[11:0]` register offset.
- `nRead`  in  1: active-low read strobe.
- `nWrite`  in  1: active-low write strobe.

## Operation
- **Writable offsets:**
  - `ALU_Source1` loads A = `DataBus[WIDTH-1:0]`.
  - `ALU_Source2` loads B the same way.
  - `AluStatusIn` issues the opcode in `DataBus[7:0]`.
- **Readable offsets (zero-extended to 256 bits):**
  - `ALU_Source1`, `ALU_Source2`.
  - `ALU_Result`: low result.
  - `ALU_ResultHi`: upper product half.
  - `ALU_Remainder`.
  - `AluStatusOut`.
  - Unknown offsets read 0.
- **Status word bits:**
  - bit0 done; bit1 busy; bits9:2 active_op.
  - bit10 divz; bit11 ovf; bit12 carry; bit13 illegal; bit14 reject.
  - All flags are cleared when an op is accepted, then set by that op.
- **Single-cycle ops:**
  - Iadd: result = A+B mod 2^WIDTH; carry = bit WIDTH of the sum.
  - Isub: result = A−B; carry = borrow (A<B unsigned).
  - Imult: full 2·WIDTH product, low half to Result, high half to ResultHi.
- **Idiv / Irem:** both load quotient into Result and remainder into Remainder; they differ only in active_op.
  - Uses `seq_div`, a restoring divider producing one quotient bit per cycle.
  - B=0: completes in one edge. Quotient 0, remainder = A, divz=1.
- **Illegal opcode:** results unchanged, illegal=1, done=1.
- **FSM states: IDLE, DIV_RUN, DIV_FIX.**
  - IDLE → DIV_RUN on divide accept with B≠0. Operand magnitudes and signs are latched at that point.
  - DIV_RUN → DIV_FIX after WIDTH iterations.
  - DIV_FIX → IDLE: sign correction applied, results written, done=1.
- **Writes while busy:**
  - An opcode write is ignored and sets reject=1, which stays set until the next accepted op.
  - Operand writes while busy are accepted but do not affect the running divide.
- **Reads while busy:** return previous results. Status shows busy=1, done=0.

## Timing
- **Reset values:** all registers, flags, active_op and FSM cleared to 0 / IDLE; bus not driven. Reset mid-divide aborts immediately.
- **Single-cycle ops:** results and done=1 are visible after the same falling edge E0 that samples the opcode write.
- **Divide:** E0 sets busy=1, done=0. Edges E1..E_WIDTH iterate; E_(WIDTH+1) sets done=1, busy=0. Total latency WIDTH+1 edges.
- **Read path:** combinational while `nRead` is low and the unit is selected.
- **Simultaneous `nRead` and `nWrite`:** the write is performed and the read returns pre-edge values.

## Configuration
- **`INT_ALU_SIGNED_EN` defined:** adds opcodes Isadd, Issub, Ismult, Isdiv, Isrem (two's complement).
  - ovf is set on signed add/sub overflow.
  - Ismult produces a signed 2·WIDTH product.
  - Isdiv truncates toward zero; the remainder takes the sign of the dividend.
  - MIN / −1 gives quotient MIN, remainder 0, ovf=1 (one edge).
- **Undefined:** these opcodes are treated as illegal and ovf always reads 0.

## Structure
- **Package `int_alu_pkg`:**
  - New opcode constants (Irem, signed set).
  - New offsets (`ALU_ResultHi`, `ALU_Remainder`).
  - Status bit positions.
  - FSM state enum.
  - Existing `params.vh` constants are reused unchanged.
- **Sub-module `seq_div`:** WIDTH-parametrised unsigned restoring divider with start, busy and done handshake. The top level handles sign and special cases.

## Test plan
All cases use WIDTH=16.
- **Add with carry:** A=0xFFFF, B=0x0001, Iadd → Result 0x0000, carry=1, done=1 after E0.
- **Full-width multiply:** A=0x1234, B=0x5678, Imult → Result 0x0060, ResultHi 0x0626.
- **Divide latency:** A=100, B=7, Idiv → busy=1 for edges E0..E16, done at E17, Result 14, Remainder 2. An opcode write mid-run sets reject=1 and the result is unaffected.
- **Divide by zero:** A=0x1234, B=0, Idiv → done at E0, Result 0, Remainder 0x1234, divz=1.
- **Signed divide** (`INT_ALU_SIGNED_EN`):
  - 0x8000 / 0xFFFF → Result 0x8000, Remainder 0, ovf=1.
  - 0xFFF9 / 0x0002 → Result 0xFFFD, Remainder 0xFFFF.
- **Reset mid-divide:** assert Reset at E5 of a divide → all reads 0, busy=0. A new Iadd issued after release completes normally.

Source files
------------

// File: rtl/int_alu_pkg.sv
// Shared constants for int_alu_mc: unit select, register offsets, opcodes,
// status bit positions and the divide FSM state type.
package int_alu_pkg;

   localparam logic [3:0]  IntAlu        = 4'h3;

   localparam logic [11:0] ALU_Source1   = 12'h000;
   localparam logic [11:0] ALU_Source2   = 12'h001;
   localparam logic [11:0] ALU_Result    = 12'h002;
   localparam logic [11:0] AluStatusIn   = 12'h003;
   localparam logic [11:0] AluStatusOut  = 12'h004;
   localparam logic [11:0] ALU_ResultHi  = 12'h005;
   localparam logic [11:0] ALU_Remainder = 12'h006;

   localparam logic [7:0]  Iadd   = 8'h01;
   localparam logic [7:0]  Isub   = 8'h02;
   localparam logic [7:0]  Imult  = 8'h03;
   localparam logic [7:0]  Idiv   = 8'h04;
   localparam logic [7:0]  Irem   = 8'h05;
   localparam logic [7:0]  Isadd  = 8'h11;
   localparam logic [7:0]  Issub  = 8'h12;
   localparam logic [7:0]  Ismult = 8'h13;
   localparam logic [7:0]  Isdiv  = 8'h14;
   localparam logic [7:0]  Isrem  = 8'h15;

   localparam int ST_DONE    = 0;
   localparam int ST_BUSY    = 1;
   localparam int ST_OP_LSB  = 2;
   localparam int ST_DIVZ    = 10;
   localparam int ST_OVF     = 11;
   localparam int ST_CARRY   = 12;
   localparam int ST_ILLEGAL = 13;
   localparam int ST_REJECT  = 14;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DIV_RUN = 2'd1,
      DIV_FIX = 2'd2
   } alu_state_e;

endpackage

// File: rtl/int_alu_mc_if.sv
// Bus control signals (address and strobes) of the shared 256-bit bus.
// The data lines themselves stay on a plain inout port of the slave.
interface int_alu_mc_if;
   logic [15:0] address;
   logic        nRead;
   logic        nWrite;

   modport master (output address, output nRead, output nWrite);
   modport slave  (input address, input nRead, input nWrite);
endinterface

// File: rtl/int_alu_mc_seq_div.sv
// seq_div: unsigned restoring divider, one quotient bit per falling edge.
// start_i latches operands; done_o is high during the edge that retires the
// last quotient bit, so quot_o/rem_o are final right after that edge.
module seq_div #(
   parameter int WIDTH = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             start_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] quot_o,
   output logic [WIDTH-1:0] rem_o
);
   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] quot_q, rem_q, dvs_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH:0]   shifted, trial;

   // partial remainder < divisor, so the shifted value always fits WIDTH+1 bits
   assign shifted = {rem_q, quot_q[WIDTH-1]};
   assign trial   = shifted - {1'b0, dvs_q};

   // iteration counter counts down to zero; quotient bits shift in from the right
   always_ff @(negedge Clk or posedge Reset) begin
      if (Reset) begin
         quot_q <= '0;
         rem_q  <= '0;
         dvs_q  <= '0;
         cnt_q  <= '0;
      end else if (start_i) begin
         quot_q <= dividend_i;
         rem_q  <= '0;
         dvs_q  <= divisor_i;
         cnt_q  <= CW'(WIDTH);
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - CW'(1);
         if (!trial[WIDTH]) begin
            rem_q  <= trial[WIDTH-1:0];
            quot_q <= {quot_q[WIDTH-2:0], 1'b1};
         end else begin
            rem_q  <= shifted[WIDTH-1:0];
            quot_q <= {quot_q[WIDTH-2:0], 1'b0};
         end
      end
   end

   assign busy_o = (cnt_q != '0);
   assign done_o = (cnt_q == CW'(1));
   assign quot_o = quot_q;
   assign rem_o  = rem_q;
endmodule

// File: rtl/int_alu_mc.sv
// int_alu_mc: multi-cycle integer ALU bus slave (add/sub/mul/div/rem).
// Optional signed opcodes are enabled by defining INT_ALU_SIGNED_EN.
// All state changes on the falling edge of Clk; Reset is async active-high.
//
// state   | meaning
// IDLE    | accepting opcodes, single-cycle ops complete here
// DIV_RUN | seq_div iterating, one quotient bit per edge
// DIV_FIX | sign correction and divide result write-back
module int_alu_mc
   import int_alu_pkg::*;
#(
   parameter int         WIDTH    = 16,
   parameter logic [3:0] UNIT_SEL = IntAlu
) (
   input  logic         Clk,
   input  logic         Reset,
   inout  wire  [255:0] DataBus,
   int_alu_mc_if.slave  bus
);
`ifdef INT_ALU_SIGNED_EN
   localparam bit SignedEn = 1'b1;
`else
   localparam bit SignedEn = 1'b0;
`endif

   alu_state_e       state_q;
   logic [WIDTH-1:0] a_q, b_q, res_q, res_hi_q, rem_q;
   logic [7:0]       active_op_q;
   logic             done_q, divz_q, ovf_q, carry_q, illegal_q, reject_q;
   logic             neg_quo_q, neg_rem_q;

   logic             sel, wr, rd, op_wr, op_legal, op_div, op_signed, min_neg1, div_start;
   logic             div_busy, div_done, add_ovf, sub_ovf;
   logic [11:0]      offs;
   logic [7:0]       opcode;
   logic [WIDTH-1:0] wdata, mag_a, mag_b, quot, rem;
   logic [WIDTH:0]   sum, diff;
   logic [2*WIDTH-1:0] prod_u, prod_s;
   logic [14:0]      status;
   logic [255:0]     rdata;
   logic             unused_bus;

   assign sel    = (bus.address[15:12] == UNIT_SEL);
   assign wr     = sel && !bus.nWrite;
   assign rd     = sel && !bus.nRead;
   assign offs   = bus.address[11:0];
   assign wdata  = DataBus[WIDTH-1:0];
   assign opcode = DataBus[7:0];
   assign op_wr  = wr && (offs == AluStatusIn);
   assign unused_bus = ^DataBus[255:WIDTH];

   // opcode classification; signed opcodes are legal only in the signed build
   always_comb begin
      op_legal  = 1'b1;
      op_div    = 1'b0;
      op_signed = 1'b0;
      case (opcode)
         Iadd, Isub, Imult:    ;
         Idiv, Irem:           op_div = 1'b1;
         Isadd, Issub, Ismult: begin op_signed = 1'b1; op_legal = SignedEn; end
         Isdiv, Isrem:         begin op_div = 1'b1; op_signed = 1'b1; op_legal = SignedEn; end
         default:              op_legal = 1'b0;
      endcase
   end

   assign sum     = {1'b0, a_q} + {1'b0, b_q};
   assign diff    = {1'b0, a_q} - {1'b0, b_q};
   assign prod_u  = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
   assign prod_s  = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
   assign add_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
   assign sub_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);

   // MIN / -1 cannot be represented; it is resolved in one edge instead of dividing
   assign min_neg1  = op_signed && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (&b_q);
   assign mag_a     = (op_signed && a_q[WIDTH-1]) ? -a_q : a_q;
   assign mag_b     = (op_signed && b_q[WIDTH-1]) ? -b_q : b_q;
   assign div_start = (state_q == IDLE) && op_wr && op_legal && op_div
                      && (b_q != '0) && !min_neg1;

   seq_div #(.WIDTH(WIDTH)) u_div (
      .Clk        (Clk),
      .Reset      (Reset),
      .start_i    (div_start),
      .dividend_i (mag_a),
      .divisor_i  (mag_b),
      .busy_o     (div_busy),
      .done_o     (div_done),
      .quot_o     (quot),
      .rem_o      (rem)
   );

   // operand registers, op dispatch, divide sequencing and status flags
   always_ff @(negedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         res_q       <= '0;
         res_hi_q    <= '0;
         rem_q       <= '0;
         active_op_q <= '0;
         done_q      <= 1'b0;
         divz_q      <= 1'b0;
         ovf_q       <= 1'b0;
         carry_q     <= 1'b0;
         illegal_q   <= 1'b0;
         reject_q    <= 1'b0;
         neg_quo_q   <= 1'b0;
         neg_rem_q   <= 1'b0;
      end else begin
         if (wr && offs == ALU_Source1) a_q <= wdata;
         if (wr && offs == ALU_Source2) b_q <= wdata;
         case (state_q)
            IDLE: if (op_wr) begin
               active_op_q <= opcode;
               done_q      <= 1'b1;
               divz_q      <= 1'b0;
               ovf_q       <= 1'b0;
               carry_q     <= 1'b0;
               illegal_q   <= 1'b0;
               reject_q    <= 1'b0;
               if (!op_legal) begin
                  illegal_q <= 1'b1;
               end else if (op_div) begin
                  if (b_q == '0) begin
                     res_q  <= '0;
                     rem_q  <= a_q;
                     divz_q <= 1'b1;
                  end else if (min_neg1) begin
                     res_q  <= a_q;
                     rem_q  <= '0;
                     ovf_q  <= 1'b1;
                  end else begin
                     done_q    <= 1'b0;
                     state_q   <= DIV_RUN;
                     neg_quo_q <= op_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                     neg_rem_q <= op_signed && a_q[WIDTH-1];
                  end
               end else begin
                  case (opcode)
                     Iadd, Isadd: begin
                        res_q   <= sum[WIDTH-1:0];
                        carry_q <= sum[WIDTH];
                        ovf_q   <= op_signed && add_ovf;
                     end
                     Isub, Issub: begin
                        res_q   <= diff[WIDTH-1:0];
                        carry_q <= diff[WIDTH];
                        ovf_q   <= op_signed && sub_ovf;
                     end
                     default: {res_hi_q, res_q} <= op_signed ? prod_s : prod_u;
                  endcase
               end
            end
            DIV_RUN: begin
               if (op_wr) reject_q <= 1'b1;
               // leave if the divider finishes, or if it is unexpectedly idle
               if (div_done || !div_busy) state_q <= DIV_FIX;
            end
            DIV_FIX: begin
               if (op_wr) reject_q <= 1'b1;
               res_q   <= neg_quo_q ? -quot : quot;
               rem_q   <= neg_rem_q ? -rem : rem;
               done_q  <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign status = {reject_q, illegal_q, carry_q, ovf_q, divz_q, active_op_q,
                    (state_q != IDLE), done_q};

   // combinational read mux, zero-extended to the bus width
   always_comb begin
      rdata = '0;
      case (offs)
         ALU_Source1:   rdata[WIDTH-1:0] = a_q;
         ALU_Source2:   rdata[WIDTH-1:0] = b_q;
         ALU_Result:    rdata[WIDTH-1:0] = res_q;
         ALU_ResultHi:  rdata[WIDTH-1:0] = res_hi_q;
         ALU_Remainder: rdata[WIDTH-1:0] = rem_q;
         AluStatusOut:  rdata[14:0]      = status;
         default:       ;
      endcase
   end

   assign DataBus = rd ? rdata : {256{1'bz}};
endmodule

// File: tb/tb_int_alu_mc.sv
// Directed self-checking bench for int_alu_mc at WIDTH=16.
module tb_int_alu_mc;
   import int_alu_pkg::*;

   logic         Clk = 1'b0;
   logic         Reset;
   wire  [255:0] DataBus;
   logic [255:0] drv;
   logic         drv_en;
   logic [255:0] d;
   int           errors = 0;
   int           checks = 0;

   assign DataBus = drv_en ? drv : {256{1'bz}};

   int_alu_mc_if bus ();

   int_alu_mc #(.WIDTH(16), .UNIT_SEL(IntAlu)) dut (
      .Clk     (Clk),
      .Reset   (Reset),
      .DataBus (DataBus),
      .bus     (bus)
   );

   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // one write, sampled by the next falling edge
   task automatic wr(input logic [11:0] o, input logic [255:0] v);
      @(posedge Clk);
      bus.address = {IntAlu, o};
      drv         = v;
      drv_en      = 1'b1;
      bus.nWrite  = 1'b0;
      @(negedge Clk);
      #1;
      bus.nWrite  = 1'b1;
      drv_en      = 1'b0;
   endtask

   task automatic rd(input logic [11:0] o, output logic [255:0] v);
      bus.address = {IntAlu, o};
      bus.nRead   = 1'b0;
      #1;
      v = DataBus;
      bus.nRead   = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      repeat (3) @(negedge Clk);
      #1;
      rd(AluStatusOut, d); checks++;
      if (d !== 256'h0) begin errors++; $display("FAIL reset_status: got %0h want 0", d); end
      @(posedge Clk);
      Reset = 1'b0;
      @(negedge Clk); #1;
      rd(ALU_Result, d); checks++;
      if (d !== 256'h0) begin errors++; $display("FAIL reset_result: got %0h want 0", d); end
      rd(ALU_Source1, d); checks++;
      if (d !== 256'h0) begin errors++; $display("FAIL reset_src1: got %0h want 0", d); end
   endtask

   task automatic test_add_sub();
      wr(ALU_Source1, 256'hFFFF);
      wr(ALU_Source2, 256'h0001);
      wr(AluStatusIn, 256'(Iadd));
      rd(ALU_Result, d); checks++;
      if (d !== 256'h0) begin errors++; $display("FAIL add_result: got %0h want 0", d); end
      rd(AluStatusOut, d); checks++;
      if (d !== 256'h1005) begin errors++; $display("FAIL add_status: got %0h want 1005", d); end
      rd(ALU_Source1, d); checks++;
      if (d !== 256'hFFFF) begin errors++; $display("FAIL src1_readback: got %0h want ffff", d); end
      wr(ALU_Source1, 256'h3);
      wr(ALU_Source2, 256'h5);
      wr(AluStatusIn, 256'(Isub));
      rd(ALU_Result, d); checks++;
      if (d !== 256'hFFFE) begin errors++; $display("FAIL sub_borrow_result: got %0h want fffe", d); end
      rd(AluStatusOut, d); checks++;
      if (d !== 256'h1009) begin errors++; $display("FAIL sub_borrow_status: got %0h want 1009", d); end
   endtask

   task automatic test_back_to_back();
      wr(ALU_Source1, 256'h2);
      wr(ALU_Source2, 256'h3);
      wr(AluStatusIn, 256'(Iadd));
      rd(ALU_Result, d); checks++;
      if (d !== 256'h5) begin errors++; $display("FAIL b2b_add: got %0h want 5", d); end
      wr(AluStatusIn, 256'(Isub));
      rd(ALU_Result, d); checks++;
      if (d !== 256'hFFFF) begin errors++; $display("FAIL b2b_sub: got %0h want ffff", d); end
      rd(AluStatusOut, d); checks++;
      if (d !== 256'h1009) begin errors++; $display("FAIL b2b_status: got %0h want 1009", d); end
   endtask

   task automatic test_mult();
      wr(ALU_Source1, 256'h1234);
      wr(ALU_Source2, 256'h5678);
      wr(AluStatusIn, 256'(Imult));
      rd(ALU_Result, d); checks++;
      if (d !== 256'h0060) begin errors++; $display("FAIL mult_lo: got %0h want 60", d); end
      rd(ALU_ResultHi, d); checks++;
      if (d !== 256'h0626) begin errors++; $display("FAIL mult_hi: got %0h want 626", d); end
      rd(AluStatusOut, d); checks++;
      if (d !== 256'h000D) begin errors++; $display("FAIL mult_status: got %0h want d", d); end
      bus.address = {IntAlu ^ 4'hF, ALU_Result};
      bus.nRead   = 1'b0;
      #1;
      d = DataBus;
      bus.nRead   = 1'b1;
      checks++;
      if (!(d === 256'h0 || d === {256{1'bz}})) begin
         errors++; $display("FAIL unselected_read: got %0h want undriven", d);
      end
   endtask

   task automatic test_div_latency();
      logic [255:0] want;
      wr(ALU_Source1, 256'd100);
      wr(ALU_Source2, 256'd7);
      wr(AluStatusIn, 256'(Idiv));
      rd(AluStatusOut, d); checks++;
      if (d !== 256'h0012) begin errors++; $display("FAIL div_e0_status: got %0h want 12", d); end
      for (int e = 1; e <= 17; e++) begin
         if (e == 6) wr(AluStatusIn, 256'(Iadd));
         else if (e == 8) wr(ALU_Source1, 256'h0);
         else begin @(negedge Clk); #1; end
         want = (e == 17) ? 256'h4011 : ((e >= 6) ? 256'h4012 : 256'h0012);
         rd(AluStatusOut, d); checks++;
         if (d !== want) begin errors++; $display("FAIL div_status_e%0d: got %0h want %0h", e, d, want); end
         if (e == 3) begin
            rd(ALU_Result, d); checks++;
            if (d !== 256'h0060) begin errors++; $display("FAIL div_busy_read: got %0h want 60", d); end
         end
      end
      rd(ALU_Result, d); checks++;
      if (d !== 256'd14) begin errors++; $display("FAIL div_quot: got %0h want e", d); end
      rd(ALU_Remainder, d); checks++;
      if (d !== 256'd2) begin errors++; $display("FAIL div_rem: got %0h want 2", d); end
      rd(ALU_Source1, d); checks++;
      if (d !== 256'h0) begin errors++; $display("FAIL div_busy_src_write: got %0h want 0", d); end
   endtask

   task automatic test_div_zero();
      wr(ALU_Source1, 256'h1234);
      wr(ALU_Source2, 256'h0);
      wr(AluStatusIn, 256'(Idiv));
      rd(AluStatusOut, d); checks++;
      if (d !== 256'h0411) begin errors++; $display("FAIL divz_status: got %0h want 411", d); end
      rd(ALU_Result, d); checks++;
      if (d !== 256'h0) begin errors++; $display("FAIL divz_quot: got %0h want 0", d); end
      rd(ALU_Remainder, d); checks++;
      if (d !== 256'h1234) begin errors++; $display("FAIL divz_rem: got %0h want 1234", d); end
      wr(AluStatusIn, 256'(Irem));
      rd(AluStatusOut, d); checks++;
      if (d !== 256'h0415) begin errors++; $display("FAIL remz_status: got %0h want 415", d); end
   endtask

   task automatic test_illegal();
      wr(ALU_Source1, 256'd9);
      wr(ALU_Source2, 256'd4);
      wr(AluStatusIn, 256'(Iadd));
      wr(AluStatusIn, 256'hEE);
      rd(AluStatusOut, d); checks++;
      if (d !== 256'h23B9) begin errors++; $display("FAIL illegal_status: got %0h want 23b9", d); end
      rd(ALU_Result, d); checks++;
      if (d !== 256'hD) begin errors++; $display("FAIL illegal_result_kept: got %0h want d", d); end
   endtask

   task automatic test_signed();
`ifdef INT_ALU_SIGNED_EN
      wr(ALU_Source1, 256'h8000);
      wr(ALU_Source2, 256'hFFFF);
      wr(AluStatusIn, 256'(Isdiv));
      rd(AluStatusOut, d); checks++;
      if (d !== 256'h0851) begin errors++; $display("FAIL sdiv_min_status: got %0h want 851", d); end
      rd(ALU_Result, d); checks++;
      if (d !== 256'h8000) begin errors++; $display("FAIL sdiv_min_quot: got %0h want 8000", d); end
      rd(ALU_Remainder, d); checks++;
      if (d !== 256'h0) begin errors++; $display("FAIL sdiv_min_rem: got %0h want 0", d); end
      wr(ALU_Source1, 256'hFFF9);
      wr(ALU_Source2, 256'h0002);
      wr(AluStatusIn, 256'(Isdiv));
      repeat (17) @(negedge Clk);
      #1;
      rd(AluStatusOut, d); checks++;
      if (d !== 256'h0051) begin errors++; $display("FAIL sdiv_status: got %0h want 51", d); end
      rd(ALU_Result, d); checks++;
      if (d !== 256'hFFFD) begin errors++; $display("FAIL sdiv_quot: got %0h want fffd", d); end
      rd(ALU_Remainder, d); checks++;
      if (d !== 256'hFFFF) begin errors++; $display("FAIL sdiv_rem: got %0h want ffff", d); end
      wr(ALU_Source1, 256'h7FFF);
      wr(ALU_Source2, 256'h0001);
      wr(AluStatusIn, 256'(Isadd));
      rd(AluStatusOut, d); checks++;
      if (d !== 256'h0845) begin errors++; $display("FAIL sadd_ovf_status: got %0h want 845", d); end
      wr(ALU_Source1, 256'hFFFE);
      wr(ALU_Source2, 256'h0003);
      wr(AluStatusIn, 256'(Ismult));
      rd(ALU_Result, d); checks++;
      if (d !== 256'hFFFA) begin errors++; $display("FAIL smult_lo: got %0h want fffa", d); end
      rd(ALU_ResultHi, d); checks++;
      if (d !== 256'hFFFF) begin errors++; $display("FAIL smult_hi: got %0h want ffff", d); end
`else
      wr(ALU_Source1, 256'h7FFF);
      wr(ALU_Source2, 256'h0001);
      wr(AluStatusIn, 256'(Isadd));
      rd(AluStatusOut, d); checks++;
      if (d !== 256'h2045) begin errors++; $display("FAIL sadd_illegal_status: got %0h want 2045", d); end
`endif
   endtask

   task automatic test_reset_mid_div();
      wr(ALU_Source1, 256'd100);
      wr(ALU_Source2, 256'd7);
      wr(AluStatusIn, 256'(Idiv));
      repeat (4) @(negedge Clk);
      @(negedge Clk);
      Reset = 1'b1;
      #1;
      rd(AluStatusOut, d); checks++;
      if (d !== 256'h0) begin errors++; $display("FAIL rst_mid_status: got %0h want 0", d); end
      rd(ALU_Source1, d); checks++;
      if (d !== 256'h0) begin errors++; $display("FAIL rst_mid_src1: got %0h want 0", d); end
      rd(ALU_Result, d); checks++;
      if (d !== 256'h0) begin errors++; $display("FAIL rst_mid_result: got %0h want 0", d); end
      @(posedge Clk);
      Reset = 1'b0;
      wr(ALU_Source1, 256'd2);
      wr(ALU_Source2, 256'd3);
      wr(AluStatusIn, 256'(Iadd));
      rd(ALU_Result, d); checks++;
      if (d !== 256'h5) begin errors++; $display("FAIL rst_mid_add: got %0h want 5", d); end
      repeat (20) @(negedge Clk);
      #1;
      rd(AluStatusOut, d); checks++;
      if (d !== 256'h0005) begin errors++; $display("FAIL rst_mid_quiet: got %0h want 5", d); end
   endtask

   initial begin
      Reset       = 1'b1;
      drv         = '0;
      drv_en      = 1'b0;
      bus.address = 16'h0;
      bus.nRead   = 1'b1;
      bus.nWrite  = 1'b1;
      test_reset();
      test_add_sub();
      test_back_to_back();
      test_mult();
      test_div_latency();
      test_div_zero();
      test_illegal();
      test_signed();
      test_reset_mid_div();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
